// File: rtl/exc_commit_seq.sv
// Exception/ERET commit sequencer: owns the CP0 write port, drains the data bus,
// walks EPC/BadVAddr/Cause/Status updates and issues the one-cycle PC redirect.
module exc_commit_seq #(
  parameter logic [31:0] VEC_BEV  = 32'hBFC00200,
  parameter logic [31:0] VEC_NORM = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_epc,
  input  logic [31:0] exc_badvaddr,
  input  logic        exc_bad_we,
  input  logic        exc_bd,
  input  logic        exc_refill,
  input  logic        eret_valid,
  input  logic        mtc0_valid,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  output logic        mtc0_ready,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic        mem_busy,
  output logic        cp0_we,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, DRAIN, W_EPC, W_BADV, W_CAUSE, W_STATUS, E_STATUS, REDIRECT
  } state_t;

  state_t      state;
  logic [4:0]  code_q;
  logic [31:0] epc_q;
  logic [31:0] badv_q;
  logic        bad_we_q;
  logic        bd_q;
  logic        exl_q;

  // Cause[6:2] is replaced by the latched code, so the live bits are never read.
  logic unused_cause;
  assign unused_cause = ^cp0_cause[6:2];

  // First write state after the bus is quiet: EPC is frozen while EXL is set.
  function automatic state_t first_write(input logic exl, input logic bad_we);
    if (!exl)       return W_EPC;
    else if (bad_we) return W_BADV;
    else            return W_CAUSE;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      flush       <= 1'b0;
      redirect_pc <= '0;
      code_q      <= '0;
      epc_q       <= '0;
      badv_q      <= '0;
      bad_we_q    <= 1'b0;
      bd_q        <= 1'b0;
      exl_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (exc_valid) begin
            code_q   <= exc_code;
            epc_q    <= exc_epc;
            badv_q   <= exc_badvaddr;
            bad_we_q <= exc_bad_we;
            bd_q     <= exc_bd;
            exl_q    <= cp0_status[1];
            // Vector resolved at accept from the Status/refill values seen then.
            redirect_pc <= (cp0_status[22] ? VEC_BEV : VEC_NORM) +
                           ((exc_refill && !cp0_status[1]) ? 32'h0 : 32'h180);
            flush    <= 1'b1;
            state    <= mem_busy ? DRAIN : first_write(cp0_status[1], exc_bad_we);
          end else if (eret_valid) begin
            redirect_pc <= cp0_epc;
            flush       <= 1'b1;
            state       <= E_STATUS;
          end
        end
        DRAIN:    if (!mem_busy) state <= first_write(exl_q, bad_we_q);
        W_EPC:    state <= bad_we_q ? W_BADV : W_CAUSE;
        W_BADV:   state <= W_CAUSE;
        W_CAUSE:  state <= W_STATUS;
        W_STATUS: state <= REDIRECT;
        E_STATUS: state <= REDIRECT;
        REDIRECT: begin
          state <= IDLE;
          flush <= 1'b0;
        end
        default:  state <= IDLE;
      endcase
    end
  end

  assign mtc0_ready     = !rst && (state == IDLE) && !exc_valid && !eret_valid;
  assign redirect_valid = !rst && (state == REDIRECT);
  assign busy           = (state != IDLE);

  always_comb begin
    cp0_we    = 1'b0;
    cp0_waddr = '0;
    cp0_wdata = '0;
    if (!rst) begin
      case (state)
        IDLE: if (mtc0_valid && mtc0_ready) begin
          cp0_we    = 1'b1;
          cp0_waddr = mtc0_addr;
          cp0_wdata = mtc0_data;
        end
        W_EPC:    begin cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = epc_q;  end
        W_BADV:   begin cp0_we = 1'b1; cp0_waddr = 5'd8;  cp0_wdata = badv_q; end
        W_CAUSE:  begin
          cp0_we    = 1'b1;
          cp0_waddr = 5'd13;
          cp0_wdata = {exl_q ? cp0_cause[31] : bd_q, cp0_cause[30:7], code_q, cp0_cause[1:0]};
        end
        W_STATUS: begin cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = cp0_status | 32'h2;  end
        E_STATUS: begin cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = cp0_status & ~32'h2; end
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_commit_seq.sv
// Bench for exc_commit_seq: per-cycle scoreboard built from the sequencing rules,
// a bench-owned CP0 register file, and literal pins on observed write order/targets.
module tb_exc_commit_seq;
  localparam int N = 512;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic        exc_valid = 0, exc_bad_we = 0, exc_bd = 0, exc_refill = 0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_epc = '0, exc_badvaddr = '0;
  logic        eret_valid = 0, mtc0_valid = 0, mem_busy = 0;
  logic [4:0]  mtc0_addr = '0;
  logic [31:0] mtc0_data = '0;
  logic        mtc0_ready, cp0_we, flush, redirect_valid, busy;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata, redirect_pc, cp0_status, cp0_cause, cp0_epc;

  logic [31:0] cp0 [32] = '{default: 32'h0};
  assign cp0_status = cp0[12];
  assign cp0_cause  = cp0[13];
  assign cp0_epc    = cp0[14];
  always @(posedge clk) if (cp0_we) cp0[cp0_waddr] <= cp0_wdata;

  exc_commit_seq dut (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc),
    .exc_badvaddr(exc_badvaddr), .exc_bad_we(exc_bad_we), .exc_bd(exc_bd),
    .exc_refill(exc_refill), .eret_valid(eret_valid), .mtc0_valid(mtc0_valid),
    .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data), .mtc0_ready(mtc0_ready),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .mem_busy(mem_busy), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endfunction

  // Expected per-cycle outputs, indexed by cycle number.
  bit          e_chk [N], e_we [N], e_rv [N], e_fl [N], e_bz [N], e_rdy [N];
  logic [4:0]  e_a [N];
  logic [31:0] e_d [N], e_pc [N];

  function automatic void set_exp(int c, bit we, logic [4:0] a, logic [31:0] d, bit rv,
                                  logic [31:0] pc, bit fl, bit bz, bit rdy);
    e_chk[c] = 1; e_we[c] = we; e_a[c] = a; e_d[c] = d; e_rv[c] = rv;
    e_pc[c] = pc; e_fl[c] = fl; e_bz[c] = bz; e_rdy[c] = rdy;
  endfunction

  function automatic void set_idle(int c);
    set_exp(c, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  always @(negedge clk) if (cyc < N && e_chk[cyc]) begin
    chk("cp0_we", cp0_we, e_we[cyc]);
    if (e_we[cyc]) begin
      chk("cp0_waddr", cp0_waddr, e_a[cyc]);
      chk("cp0_wdata", cp0_wdata, e_d[cyc]);
    end
    chk("redirect_valid", redirect_valid, e_rv[cyc]);
    if (e_rv[cyc]) chk("redirect_pc", redirect_pc, e_pc[cyc]);
    chk("flush", flush, e_fl[cyc]);
    chk("busy", busy, e_bz[cyc]);
    chk("mtc0_ready", mtc0_ready, e_rdy[cyc]);
  end

  logic [4:0]  obs_a [$];
  logic [31:0] obs_d [$], obs_pc [$];
  int          obs_rc [$];
  always @(negedge clk) begin
    if (cp0_we) begin obs_a.push_back(cp0_waddr); obs_d.push_back(cp0_wdata); end
    if (redirect_valid) begin obs_pc.push_back(redirect_pc); obs_rc.push_back(cyc); end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_a.delete(); obs_d.delete(); obs_pc.delete(); obs_rc.delete();
  endtask

  task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
    set_exp(cyc, 1, a, d, 0, 0, 0, 0, 1);
    mtc0_valid = 1; mtc0_addr = a; mtc0_data = d;
    step();
    mtc0_valid = 0;
    set_idle(cyc);
    step();
  endtask

  // Expected exception sequence: optional drain cycles, then the writes that apply,
  // then one redirect cycle. side=1 also raises MTC0 and ERET, which must lose.
  task automatic run_exc(input logic [4:0] code, input logic [31:0] epc, input logic [31:0] badv,
                         input bit bad_we, input bit bd, input bit refill, input int ndrain,
                         input bit side, input int rst_at, output int t0);
    int t, k, last;
    logic [31:0] st, ca;
    bit exl, bev;
    t = cyc; t0 = t;
    st = cp0[12]; ca = cp0[13]; exl = st[1]; bev = st[22];
    clear_obs();
    exc_valid = 1; exc_code = code; exc_epc = epc; exc_badvaddr = badv;
    exc_bad_we = bad_we; exc_bd = bd; exc_refill = refill; mem_busy = (ndrain > 0);
    mtc0_valid = side; mtc0_addr = 5'd9; mtc0_data = 32'hDEADBEEF; eret_valid = side;
    set_exp(t, 0, 0, 0, 0, 0, 0, 0, 0);
    k = t + 1;
    repeat (ndrain) begin set_exp(k, 0, 0, 0, 0, 0, 1, 1, 0); k++; end
    if (!exl)   begin set_exp(k, 1, 14, epc, 0, 0, 1, 1, 0); k++; end
    if (bad_we) begin set_exp(k, 1, 8, badv, 0, 0, 1, 1, 0); k++; end
    set_exp(k, 1, 13, {exl ? ca[31] : bd, ca[30:7], code, ca[1:0]}, 0, 0, 1, 1, 0); k++;
    set_exp(k, 1, 12, st | 32'h2, 0, 0, 1, 1, 0); k++;
    set_exp(k, 0, 0, 0, 1, (bev ? 32'hBFC00200 : 32'h80000000) +
            ((refill && !exl) ? 32'h0 : 32'h180), 1, 1, 0);
    last = k + 2;
    set_idle(k + 1); set_idle(k + 2);
    if (rst_at >= 0) begin
      set_exp(t + rst_at, 0, 0, 0, 0, 0, 1, 1, 0);
      for (int c = t + rst_at + 1; c <= last; c++) set_idle(c);
    end
    step();
    exc_valid = 0; mtc0_valid = 0; eret_valid = 0;
    exc_bad_we = 0; exc_bd = 0; exc_refill = 0;
    while (cyc <= last) begin
      mem_busy = (cyc - t < ndrain);
      rst = (rst_at >= 0) && (cyc == t + rst_at);
      step();
    end
    rst = 0; mem_busy = 0;
  endtask

  task automatic run_eret(output int t0);
    int t;
    logic [31:0] st, ep;
    t = cyc; t0 = t; st = cp0[12]; ep = cp0[14];
    clear_obs();
    set_exp(t, 0, 0, 0, 0, 0, 0, 0, 0);
    set_exp(t + 1, 1, 12, st & ~32'h2, 0, 0, 1, 1, 0);
    set_exp(t + 2, 0, 0, 0, 1, ep, 1, 1, 0);
    set_idle(t + 3);
    eret_valid = 1;
    step();
    eret_valid = 0;
    while (cyc <= t + 3) step();
  endtask

  initial begin
    int t, n9;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_flush", flush, 0);
    chk("rst_cp0_we", cp0_we, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_mtc0_ready", mtc0_ready, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_cp0_waddr", cp0_waddr, 0);
    chk("rst_cp0_wdata", cp0_wdata, 0);
    rst = 0;
    step();

    // MTC0 alone, then the full exception sequence.
    do_mtc0(12, 32'h0);
    do_mtc0(13, 32'h0000_0300);
    run_exc(5'h04, 32'h8000_1000, 32'h8000_1002, 1, 0, 0, 0, 0, -1, t);
    chk("full_nwrites", obs_a.size(), 4);
    chk("full_w0", obs_a[0], 14);
    chk("full_w1", obs_a[1], 8);
    chk("full_w2", obs_a[2], 13);
    chk("full_w3", obs_a[3], 12);
    chk("full_cause", obs_d[2], 32'h0000_0310);
    chk("full_pc", obs_pc[0], 32'h8000_0180);
    chk("full_rcyc", obs_rc[0] - t, 5);

    // Drain: mem_busy high for the accept cycle and two more.
    do_mtc0(12, 32'h0);
    run_exc(5'h04, 32'h8000_1000, 32'h8000_1002, 1, 0, 0, 3, 0, -1, t);
    chk("drain_rcyc", obs_rc[0] - t, 8);

    // TLB refill with BEV=1, EXL=0 then EXL=1 (BD bit must stay as written before).
    do_mtc0(12, 32'h0040_0000);
    run_exc(5'h02, 32'h8000_3000, 32'h0040_1000, 1, 1, 1, 0, 0, -1, t);
    chk("refill_pc", obs_pc[0], 32'hBFC0_0200);
    run_exc(5'h02, 32'h8000_4000, 32'h0040_2000, 1, 0, 1, 0, 0, -1, t);
    chk("exl_nwrites", obs_a.size(), 3);
    chk("exl_w0", obs_a[0], 8);
    chk("exl_bd", obs_d[1][31], 1);
    chk("exl_pc", obs_pc[0], 32'hBFC0_0380);

    // ERET.
    do_mtc0(14, 32'h8000_2000);
    do_mtc0(12, 32'h0000_0003);
    run_eret(t);
    chk("eret_w0", obs_a[0], 12);
    chk("eret_d0", obs_d[0], 32'h0000_0001);
    chk("eret_pc", obs_pc[0], 32'h8000_2000);
    chk("eret_rcyc", obs_rc[0] - t, 2);

    // Exception beats a simultaneous MTC0 and ERET.
    do_mtc0(12, 32'h0);
    run_exc(5'h0c, 32'h8000_5000, 32'h0, 0, 0, 0, 0, 1, -1, t);
    n9 = 0;
    foreach (obs_a[i]) if (obs_a[i] == 5'd9) n9++;
    chk("arb_no_mtc0", n9, 0);
    chk("arb_w0", obs_a[0], 14);

    // Reset while in W_CAUSE (accept + 3).
    do_mtc0(12, 32'h0);
    run_exc(5'h04, 32'h8000_6000, 32'h8000_6004, 1, 0, 0, 0, 0, 3, t);
    chk("rst_mid_nwrites", obs_a.size(), 2);
    chk("rst_mid_noredirect", obs_pc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exc_commit_seq.md
# exc_commit_seq

Exception/ERET commit sequencer for the MIPS pipeline. It owns the single CP0 write port and shares it between MTC0 (from the writeback stage) and the multi-cycle exception and ERET update sequences. It also drains outstanding data-bus transactions, holds the pipeline flushed, and emits the one-cycle PC redirect to the handler vector or to EPC. It sits between the commit-stage exception detector and the CP0 register file / PC-select logic.

## Interface
Parameters:
- `VEC_BEV`, default `32'hBFC00200`: exception base when Status.BEV=1.
- `VEC_NORM`, default `32'h80000000`: exception base when Status.BEV=0.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `exc_valid` in 1: exception taken at commit (already qualified by EXL/IE upstream).
- `exc_code` in 5: ExcCode.
- `exc_epc` in 32: EPC value, already BD-adjusted.
- `exc_badvaddr` in 32: faulting address.
- `exc_bad_we` in 1: BadVAddr must be written.
- `exc_bd` in 1: faulting instruction was in a delay slot.
- `exc_refill` in 1: TLB refill exception.
- `eret_valid` in 1: ERET committing.
- `mtc0_valid` in 1: MTC0 write request.
- `mtc0_addr` in 5: MTC0 destination register.
- `mtc0_data` in 32: MTC0 write data.
- `mtc0_ready` out 1: MTC0 accepted this cycle.
- `cp0_status` in 32: current Status.
- `cp0_cause` in 32: current Cause.
- `cp0_epc` in 32: current EPC.
- `mem_busy` in 1: data-bus transaction outstanding.
- `cp0_we` out 1: CP0 write strobe.
- `cp0_waddr` out 5: CP0 write address.
- `cp0_wdata` out 32: CP0 write data.
- `flush` out 1: flush all pipeline stages.
- `redirect_valid` out 1: PC redirect strobe.
- `redirect_pc` out 32: redirect target.
- `busy` out 1: state is not IDLE.

## Operation
- **States:** IDLE, DRAIN, W_EPC, W_BADV, W_CAUSE, W_STATUS, E_STATUS, REDIRECT.
- **IDLE priority:** exc_valid > eret_valid > mtc0_valid.
- **Exception accept (IDLE & exc_valid):**
  - Latch code, epc, badvaddr, bad_we, bd, refill, and Status.EXL/BEV.
  - Next state is DRAIN if mem_busy, else W_EPC.
- **DRAIN:** stay while mem_busy; go to W_EPC when mem_busy=0.
- **W_EPC:** cp0 write reg 14 = latched epc. Skipped (go straight to W_BADV logic) if latched EXL=1.
- **W_BADV:** cp0 write reg 8 = latched badvaddr. Skipped if bad_we=0.
- **W_CAUSE:** cp0 write reg 13 = {EXL ? cp0_cause[31] : bd, cp0_cause[30:7], code, cp0_cause[1:0]}.
- **W_STATUS:** cp0 write reg 12 = cp0_status | 32'h2, then go to REDIRECT.
- **Exception redirect target:** (BEV ? VEC_BEV : VEC_NORM) + ((refill && !EXL) ? 0 : 32'h180), using the latched values.
- **ERET accept (IDLE & eret_valid & !exc_valid):**
  - Latch cp0_epc, then go to E_STATUS.
  - E_STATUS writes reg 12 = cp0_status & ~32'h2, then go to REDIRECT with target = latched EPC.
- **REDIRECT:** redirect_valid=1 for exactly one cycle, then IDLE.
- **MTC0:**
  - mtc0_ready = (IDLE & !exc_valid & !eret_valid).
  - When mtc0_valid & mtc0_ready: cp0_we=1, waddr=mtc0_addr, wdata=mtc0_data in the same cycle (combinational pass-through).
- **Requests while busy:** exc_valid and eret_valid are ignored, mtc0_ready=0. Upstream is flushed.
- **Output defaults:** cp0_we=0 and redirect_valid=0 outside the cases above.

## Timing
- **Reset values:** state IDLE; cp0_we, flush, redirect_valid, busy, mtc0_ready all 0. redirect_pc, cp0_waddr, and cp0_wdata are 0 in the cycle after the reset edge.
- **Reset mid-sequence:** abandon immediately, no further CP0 writes, no redirect.
- **flush:** registered. High from the cycle after accept through the REDIRECT cycle inclusive; low in IDLE.
- **Exception latency, no drain, EXL=0, bad_we=1 (accept at T):**
  - W_EPC at T+1, W_BADV at T+2, W_CAUSE at T+3, W_STATUS at T+4.
  - REDIRECT at T+5, IDLE at T+6.
- **Exception with drain:** each DRAIN cycle adds one cycle.
- **Exception with skips:** each skipped write removes one cycle.
- **ERET latency:** E_STATUS at T+1, REDIRECT at T+2.
- **CP0 writes:** at most one per cycle; the write is visible in CP0 inputs the following cycle.

## Test plan
- **Exception, full sequence:**
  - Stimulus: exc_valid, code=5'h04, epc=32'h8000_1000, badvaddr=32'h8000_1002, bad_we=1, BEV=0, EXL=0, mem_busy=0.
  - Required: writes at T+1..T+4 to regs 14, 8, 13, 12, in that order; redirect_pc=32'h8000_0180 at T+5; flush high T+1..T+5.
- **Drain:**
  - Stimulus: same as above with mem_busy=1 for 3 cycles.
  - Required: no CP0 write until mem_busy falls; redirect at T+8.
- **TLB refill, BEV=1:**
  - Stimulus: refill=1, EXL=0, BEV=1, bad_we=1.
  - Required: redirect_pc=32'hBFC0_0200.
  - Stimulus: same with EXL=1.
  - Required: no reg 14 write; Cause BD preserved; target 32'hBFC0_0380.
- **ERET:**
  - Stimulus: eret_valid, cp0_epc=32'h8000_2000, Status=32'h0000_0003.
  - Required: reg 12 write of 32'h0000_0001 at T+1; redirect_pc=32'h8000_2000 at T+2.
- **Arbitration:**
  - Stimulus: mtc0_valid with exc_valid in the same cycle.
  - Required: mtc0_ready=0; MTC0 not performed; exception sequence runs.
  - Stimulus: mtc0_valid alone in IDLE.
  - Required: ready=1; same-cycle write.
- **Reset mid-sequence:**
  - Stimulus: rst asserted in W_CAUSE.
  - Required: next cycle busy=0, flush=0, cp0_we=0; no redirect ever issued.
